// File: rtl/iq_fir_filter_nco.sv
// Quadrature 2-bit tone generator plus an 8-tap symmetric low-pass FIR with a
// valid/ready handshake. The tone generator and the filter share only the clock.
module iq_fir_filter_nco #(
    parameter int DIV   = 5,
    parameter int NTAPS = 8,
    parameter int SHIFT = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] data_in,
    input  logic       in_valid,
    output logic       pret,
    output logic [4:0] data_out,
    output logic       out_valid,
    output logic [1:0] sine_out,
    output logic [1:0] cosine_out
);

    localparam int DATA_W = 5;
    localparam int COEF_W = 4;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = $clog2(DIV + 1);
    localparam int KW     = $clog2(NTAPS);

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DONE} state_t;

    function automatic logic [1:0] sine_lut(input logic [2:0] p);
        case (p)
            3'd0: return 2'd2;
            3'd1: return 2'd3;
            3'd2: return 2'd3;
            3'd3: return 2'd2;
            3'd4: return 2'd1;
            3'd5: return 2'd0;
            3'd6: return 2'd0;
            default: return 2'd1;
        endcase
    endfunction

    function automatic logic [1:0] cosine_lut(input logic [2:0] p);
        case (p)
            3'd0: return 2'd3;
            3'd1: return 2'd2;
            3'd2: return 2'd1;
            3'd3: return 2'd0;
            3'd4: return 2'd0;
            3'd5: return 2'd1;
            3'd6: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [COEF_W-1:0] coef(input logic [KW-1:0] i);
        case (i)
            3'd0: return 4'd1;
            3'd1: return 4'd3;
            3'd2: return 4'd5;
            3'd3: return 4'd7;
            3'd4: return 4'd7;
            3'd5: return 4'd5;
            3'd6: return 4'd3;
            default: return 4'd1;
        endcase
    endfunction

    // Round half up, then clamp to the DAC range.
    function automatic logic [DATA_W-1:0] round_sat(input logic [ACC_W-1:0] a);
        logic [ACC_W:0] r;
        r = ({1'b0, a} + (ACC_W+1)'(1 << (SHIFT - 1))) >> SHIFT;
        if (r > (ACC_W+1)'(2**DATA_W - 1))
            return '1;
        return r[DATA_W-1:0];
    endfunction

    logic [CNT_W-1:0]  div_cnt;
    logic [2:0]        phase;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt    <= '0;
            phase      <= '0;
            sine_out   <= 2'd2;
            cosine_out <= 2'd3;
        end else begin
            if (div_cnt == CNT_W'(DIV - 1)) begin
                div_cnt <= '0;
                phase   <= phase + 3'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            sine_out   <= sine_lut(phase);
            cosine_out <= cosine_lut(phase);
        end
    end

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  taps [NTAPS];
    logic [ACC_W-1:0]   acc;
    logic [KW-1:0]      k;
    logic               iv_q;
    logic               accept;
    logic [ACC_W-1:0]   prod;

    // pret gates acceptance so the first edge after reset cannot take a sample.
    assign accept = (state == ST_IDLE) && pret && in_valid && !iv_q;
    assign prod   = ACC_W'(taps[k]) * ACC_W'(coef(k));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_MAC;
            ST_MAC:  if (k == KW'(NTAPS - 1)) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            for (int i = 0; i < NTAPS; i++) taps[i] <= '0;
            acc       <= '0;
            k         <= '0;
            iv_q      <= 1'b0;
            pret      <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            iv_q      <= in_valid;
            pret      <= (state_nxt == ST_IDLE);
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        for (int i = NTAPS - 1; i > 0; i--) taps[i] <= taps[i-1];
                        taps[0] <= data_in;
                        acc     <= '0;
                        k       <= '0;
                    end
                end
                ST_MAC: begin
                    acc <= acc + prod;
                    k   <= k + 1'b1;
                end
                ST_DONE: begin
                    data_out  <= round_sat(acc);
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_fir_filter_nco.sv
// Directed/randomized bench for iq_fir_filter_nco against a transaction-level
// convolution and tone-table reference model.
module tb_iq_fir_filter_nco;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] data_in = '0;
    logic       in_valid = 1'b0;
    logic       pret;
    logic [4:0] data_out;
    logic       out_valid;
    logic [1:0] sine_out;
    logic [1:0] cosine_out;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int cyc, free_at, exp_due, exp_val, last_out, prev_iv;
    int hist[8];
    int coefs[8]   = '{1, 3, 5, 7, 7, 5, 3, 1};
    int sin_tab[8] = '{2, 3, 3, 2, 1, 0, 0, 1};
    int cos_tab[8] = '{3, 2, 1, 0, 0, 1, 2, 3};
    int dirac_exp[10] = '{1, 3, 5, 7, 7, 5, 3, 1, 0, 0};
    int step_exp[8]   = '{1, 4, 9, 16, 22, 27, 30, 31};
    int outs[$];

    iq_fir_filter_nco dut (
        .clk        (clk),
        .resetn     (resetn),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .pret       (pret),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .sine_out   (sine_out),
        .cosine_out (cosine_out)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc      = 0;
        free_at  = 2;
        exp_due  = -1;
        exp_val  = 0;
        last_out = 0;
        prev_iv  = 0;
        foreach (hist[i]) hist[i] = 0;
    endtask

    // One clock: update the model with what the DUT sees at the edge, then check.
    task automatic step();
        int acc;
        int ph;
        @(posedge clk);
        cyc++;
        if (in_valid && prev_iv == 0 && cyc >= free_at) begin
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = data_in;
            acc = 0;
            for (int i = 0; i < 8; i++) acc += coefs[i] * hist[i];
            exp_val = (acc + 16) / 32;
            if (exp_val > 31) exp_val = 31;
            exp_due = cyc + 9;
            free_at = cyc + 10;
        end
        prev_iv = in_valid;
        #1;
        if (cyc == exp_due) last_out = exp_val;
        chk("out_valid", out_valid, cyc == exp_due);
        chk("data_out", data_out, last_out);
        chk("pret", pret, cyc >= free_at - 1);
        ph = ((cyc - 1) / 5) % 8;
        chk("sine_out", sine_out, sin_tab[ph]);
        chk("cosine_out", cosine_out, cos_tab[ph]);
        if (out_valid === 1'b1) outs.push_back(int'(data_out));
    endtask

    task automatic send(input logic [4:0] v);
        int g = 0;
        while (cyc + 1 < free_at && g < 40) begin
            step();
            g++;
        end
        if (g >= 40) begin
            mismatched++;
            $error("FAIL send_wait: observed timeout expected ready");
        end
        data_in  = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_pret"}, pret, 0);
        chk({tag, "_sine"}, sine_out, 2);
        chk({tag, "_cosine"}, cosine_out, 3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #30;
        check_reset_vals("reset");
        #30 resetn = 1'b1;

        // Idle run: generator alone
        repeat (6) step();

        // Dirac: one full-scale sample then zeros
        outs.delete();
        send(5'd31);
        repeat (9) send(5'd0);
        repeat (11) step();
        chk("dirac_count", outs.size(), 10);
        for (int i = 0; i < 10 && i < outs.size(); i++)
            chk($sformatf("dirac_%0d", i), outs[i], dirac_exp[i]);

        // Step: constant full scale
        outs.delete();
        repeat (8) send(5'd31);
        repeat (11) step();
        chk("step_count", outs.size(), 8);
        for (int i = 0; i < 8 && i < outs.size(); i++)
            chk($sformatf("step_%0d", i), outs[i], step_exp[i]);

        // Handshake: high 3, low 2, with edges landing while busy
        for (int i = 0; i < 60; i++) begin
            in_valid = ((i % 5) < 3);
            if (i % 5 == 0) data_in = 5'($urandom_range(0, 31));
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();

        // Random valid/data
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            data_in  = 5'($urandom_range(0, 31));
            step();
        end
        in_valid = 1'b0;
        repeat (12) step();

        // Tone: feed the sine back, offered every 5 clocks
        for (int i = 0; i < 150; i++) begin
            in_valid = (i % 5 == 0);
            if (i % 5 == 0) data_in = {sine_out, 3'b000};
            step();
        end
        in_valid = 1'b0;
        repeat (12) step();

        // Reset in the middle of a MAC sequence
        send(5'd20);
        repeat (4) step();
        #3 resetn = 1'b0;
        #2;
        check_reset_vals("midreset");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        model_reset();

        // Taps must be clear after the abort
        outs.delete();
        send(5'd31);
        repeat (12) step();
        chk("post_reset_count", outs.size(), 1);
        if (outs.size() > 0) chk("post_reset_out", outs[0], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
